// File: rtl/dvi_seq_pkg.sv
// Shared types and constants for the DVI raster sequencer.
package dvi_seq_pkg;

  // Width of the horizontal and vertical raster counters.
  localparam int unsigned CntW = 12;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StRun
  } seq_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [0:7][23:0] BarRgb = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic pixel_t bar_color(input logic [2:0] idx);
    return pixel_t'(BarRgb[idx]);
  endfunction

endpackage

// File: rtl/dvi_timing_sequencer_if.sv
// Upstream pixel stream: valid/ready handshake with a start-of-frame qualifier.
interface dvi_timing_sequencer_if;
  import dvi_seq_pkg::*;

  logic   pix_valid;
  logic   pix_sof;
  pixel_t pix_data;
  logic   pix_rdy;

  // Framebuffer FIFO side.
  modport master (
    output pix_valid,
    output pix_sof,
    output pix_data,
    input  pix_rdy
  );

  // Sequencer side.
  modport slave (
    input  pix_valid,
    input  pix_sof,
    input  pix_data,
    output pix_rdy
  );

endinterface

// File: rtl/dvi_timing_counter.sv
// Raster h/v counters with active, sync-window and end-of-frame decode.
// Counters are held at the origin while run is low.
module dvi_timing_counter
  import dvi_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic            clkin,
  input  logic            rstin_n,
  input  logic            run,
  output logic [CntW-1:0] h,
  output logic [CntW-1:0] v,
  output logic            active,
  output logic            hsync_on,
  output logic            vsync_on,
  output logic            frame_end
);

  localparam logic [CntW-1:0] HAct     = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] HSyncBeg = CntW'(H_ACTIVE + H_FP);
  localparam logic [CntW-1:0] HSyncEnd = CntW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntW-1:0] HLast    = CntW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CntW-1:0] VAct     = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] VSyncBeg = CntW'(V_ACTIVE + V_FP);
  localparam logic [CntW-1:0] VSyncEnd = CntW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CntW-1:0] VLast    = CntW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [CntW-1:0] h_q, v_q;

  // Advance the raster position; v steps when h wraps.
  always_ff @(posedge clkin) begin
    if (!rstin_n || !run) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == HLast) begin
      h_q <= '0;
      v_q <= (v_q == VLast) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  // Region decode from the current position.
  always_comb begin
    h         = h_q;
    v         = v_q;
    active    = (h_q < HAct) && (v_q < VAct);
    hsync_on  = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    vsync_on  = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    frame_end = (h_q == HLast) && (v_q == VLast);
  end

endmodule

// File: rtl/dvi_timing_sequencer.sv
// DVI raster sequencer: drives DE/HSYNC/VSYNC and RGB to the three TMDS encoders,
// pulls pixels from an upstream stream, blanks and re-locks on underflow or misalignment.
// Optional build macro: DVI_SEQ_COLORBAR_EN (colour-bar fill instead of black).
module dvi_timing_sequencer
  import dvi_seq_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic                          clkin,
  input  logic                          rstin_n,
  input  logic                          enable,
  dvi_timing_sequencer_if.slave         pix,
  output logic                          enc_de,
  output logic                          enc_b_c0,
  output logic                          enc_b_c1,
  output logic [7:0]                    enc_r,
  output logic [7:0]                    enc_g,
  output logic [7:0]                    enc_b,
  output logic                          frame_start,
  output logic                          underflow
);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] h, v;
  logic            active, hsync_on, vsync_on, frame_end;
  logic            running, at_origin, rdy, take, err;
  pixel_t          fill, data_d;

  assign running = (state_q != StIdle);

  dvi_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_cnt (
    .clkin     (clkin),
    .rstin_n   (rstin_n),
    .run       (running),
    .h         (h),
    .v         (v),
    .active    (active),
    .hsync_on  (hsync_on),
    .vsync_on  (vsync_on),
    .frame_end (frame_end)
  );

`ifdef DVI_SEQ_COLORBAR_EN
  localparam int unsigned BarW = H_ACTIVE / 8;

  // Eight equal-width vertical bars across the active line.
  always_comb begin
    fill = bar_color(3'(h / CntW'(BarW)));
  end
`else
  // Blanked picture is plain black.
  always_comb begin
    fill = '0;
  end
`endif

  // Handshake, error detection, next state and next pixel.
  always_comb begin
    at_origin = (h == '0) && (v == '0);
    rdy       = 1'b0;
    case (state_q)
      // SOF must coincide exactly with the origin; a mismatch is refused.
      StRun:   rdy = active && (pix.pix_sof == at_origin);
      // Flush stale pixels but hold an SOF pixel for the next frame.
      StSync:  rdy = pix.pix_valid && !pix.pix_sof;
      default: rdy = 1'b0;
    endcase
    take = (state_q == StRun) && rdy && pix.pix_valid;
    err  = (state_q == StRun) && active && !take;

    state_d = state_q;
    case (state_q)
      StIdle: if (enable) state_d = StSync;
      StSync: begin
        if (frame_end) begin
          if (!enable)                            state_d = StIdle;
          else if (pix.pix_valid && pix.pix_sof) state_d = StRun;
        end
      end
      StRun: begin
        if (err)                      state_d = StSync;
        else if (frame_end && !enable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (take)                 data_d = pix.pix_data;
    else if (running && active) data_d = fill;
    else                      data_d = '0;
  end

  assign pix.pix_rdy = rdy;

  // State register plus registered encoder outputs, one cycle behind the counters.
  always_ff @(posedge clkin) begin
    if (!rstin_n) begin
      state_q     <= StIdle;
      enc_de      <= 1'b0;
      enc_b_c0    <= ~HSYNC_POL;
      enc_b_c1    <= ~VSYNC_POL;
      enc_r       <= '0;
      enc_g       <= '0;
      enc_b       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_de      <= running && active;
      enc_b_c0    <= (running && hsync_on) ? HSYNC_POL : ~HSYNC_POL;
      enc_b_c1    <= (running && vsync_on) ? VSYNC_POL : ~VSYNC_POL;
      enc_r       <= data_d.r;
      enc_g       <= data_d.g;
      enc_b       <= data_d.b;
      frame_start <= take && at_origin;
      underflow   <= underflow || err;
    end
  end

endmodule

// File: doc/dvi_timing_sequencer.md
Name: dvi_timing_sequencer

Overview:
- Raster controller that sequences the three TMDS channel encoders: generates DE, HSYNC and VSYNC, and pulls 24-bit RGB pixels from an upstream stream (framebuffer FIFO) with a valid/ready handshake.
- Drives each channel encoder's de/c0/c1/din inputs. Blue carries HSYNC on c0 and VSYNC on c1; green and red control bits are tied to 0.
- Detects stream underflow and frame misalignment, blanks the picture, and re-locks to the next start-of-frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of HSYNC
- VSYNC_POL, 0, asserted level of VSYNC

Ports:
- clkin  in  1  pixel clock; the single clock of the block
- rstin_n  in  1  synchronous, active-low reset
- enable  in  1  run request
- pix_valid  in  1  upstream pixel valid
- pix_sof  in  1  qualifies pix_data as first pixel of a frame
- pix_data  in  24  {R[23:16],G[15:8],B[7:0]}
- pix_rdy  out  1  pixel accepted when pix_valid&pix_rdy
- enc_de  out  1  DE to all three encoders
- enc_b_c0  out  1  HSYNC to blue encoder
- enc_b_c1  out  1  VSYNC to blue encoder
- enc_r, enc_g, enc_b  out  8 each  channel data
- frame_start  out  1  one-cycle pulse aligned with first active pixel output
- underflow  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rstin_n=0 at a clkin edge):
  - State IDLE; h=v=0.
  - enc_de=0, syncs at inactive level (~POL), data 0.
  - pix_rdy=0, frame_start=0, underflow=0.
  - Reset mid-frame aborts immediately; nothing is retained.
- Counters:
  - h runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v runs 0..V_TOTAL-1 and increments when h wraps.
  - Both are 12 bits.
  - Active region: h<H_ACTIVE && v<V_ACTIVE.
  - HSYNC asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; VSYNC uses the same form with the V parameters.
  - Counters are frozen at 0 in IDLE and free-run in every other state.
- Latency:
  - All encoder outputs are registered, 1 cycle after the counter state.
  - The pixel accepted at counter (h,v) appears on enc_* in the next cycle together with its DE.
- pix_rdy: combinational; 1 only in RUN during the active region, or in SYNC while pix_valid&~pix_sof (flush).
- States:
  - IDLE: outputs blank, syncs inactive. enable=1 -> SYNC.
  - SYNC:
    - Timing runs; the active region outputs fill colour with DE=1.
    - Non-SOF pixels are discarded; an SOF pixel is held (not accepted).
    - At h=H_TOTAL-1 && v=V_TOTAL-1 with pix_valid&pix_sof -> RUN.
    - Otherwise remain in SYNC.
  - RUN:
    - Every active-region cycle consumes one pixel.
    - Underflow: active cycle with pix_valid=0. Output fill colour for that pixel, set underflow -> SYNC.
    - Misalignment: pix_sof=1 at any active pixel other than (0,0), or pix_sof=0 at (0,0). Do not accept the pixel, output fill, set underflow -> SYNC.
    - Misalignment takes priority over a normal transfer.
  - Disable: enable=0 in SYNC/RUN takes effect at the end of the frame (h=H_TOTAL-1, v=V_TOTAL-1) -> IDLE. Re-asserting enable before then cancels it.
- frame_start pulses with the registered output of pixel (0,0) in RUN only.
- Fill colour is 0x000000 (black) unless the optional feature is compiled in.

Optional Feature:
- Macro: DVI_SEQ_COLORBAR_EN.
- Defined: fill colour is 8 vertical bars, bar index = h / (H_ACTIVE/8), in order white, yellow, cyan, green, magenta, red, blue, black (full-scale 0xFF/0x00 components).
- Undefined: fill is black and no bar logic is synthesised.

Decomposition:
- Package dvi_seq_pkg:
  - state enum {IDLE, SYNC, RUN}
  - 12-bit counter width constant
  - colour-bar RGB constant table
  - pixel struct {r,g,b}
- Sub-module dvi_timing_counter: h/v counters, run/freeze control, active/hsync/vsync/frame-end decode.
- The sequencer FSM, handshake, fill mux and output registers stay in the top level.

Test Plan:
- Reset then enable=1 with pix_valid=0 throughout:
  - enc_de high for exactly 640 cycles per line, 480 lines.
  - HSYNC low for 96 cycles at h=656..751; VSYNC low for lines 490..491.
  - H_TOTAL=800, V_TOTAL=525 verified.
  - underflow stays 0 (SYNC does not flag).
- Continuous pixel stream with counter-ramp data and SOF on the first pixel:
  - RUN is entered at the next frame boundary.
  - enc_r/g/b equal the accepted pix_data one cycle later.
  - frame_start pulses once per frame.
  - 307200 transfers per frame.
- pix_valid dropped for 1 cycle at (100,20):
  - That pixel outputs fill; underflow=1 and stays set.
  - pix_rdy flushes non-SOF pixels.
  - RUN resumes at the next frame's (0,0) when SOF is presented.
- pix_sof=1 injected at (5,0):
  - Pixel not accepted, underflow=1, state SYNC.
  - The held SOF pixel is displayed at the next (0,0).
- enable deasserted at v=200:
  - Frame completes through v=524.
  - Then IDLE: syncs inactive, pix_rdy=0.
  - rstin_n low mid-line forces all outputs to reset values on the next edge.
- With DVI_SEQ_COLORBAR_EN defined, during SYNC:
  - Line pixels 0..79 output 0xFFFFFF.
  - Pixels 80..159 output 0xFFFF00.
  - Pixels 560..639 output 0x000000.
